// File: rtl/uart_boot_loader_pkg.sv
// Shared definitions for the boot loader, the UART receiver and their benches.
package uart_boot_loader_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_DONE  = 2'd1,
        ST_ERROR = 2'd2
    } state_e;

    localparam int unsigned CLK_HZ         = 100_000_000;
    localparam int unsigned BAUD           = 9600;
    // Rounded to nearest: 100 MHz / 9600 = 10416.67 -> 10417
    localparam int unsigned CLKS_PER_BIT   = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Byte-stream input and instruction-memory write side of the boot loader.
interface uart_boot_loader_if #(
    parameter int unsigned IMAGE_BYTES = 52,
    parameter int unsigned ADDR_W      = 8
);
    localparam int unsigned CNT_W = $clog2(IMAGE_BYTES + 1);

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              frame_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic              load_err;
    logic [CNT_W-1:0]  bytes_rcvd;

    modport master (
        output byte_valid, byte_data, frame_err,
        input  mem_we, mem_addr, mem_wdata, cpu_run, load_err, bytes_rcvd
    );

    modport slave (
        input  byte_valid, byte_data, frame_err,
        output mem_we, mem_addr, mem_wdata, cpu_run, load_err, bytes_rcvd
    );

endinterface

// File: rtl/uart_boot_loader_word_packer.sv
// Little-endian byte-to-word assembly with zero padding and a separate write register.
module uart_boot_loader_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        accept_i,
    input  logic [1:0]  lane_i,
    input  logic        last_i,
    input  logic [7:0]  byte_i,
    output logic        word_ready_o,
    output logic [31:0] word_o
);

    logic [31:0] asm_q;
    logic [31:0] asm_d;
    logic [31:0] word_q;
    logic        ready_q;

    always_comb begin
        asm_d = asm_q;
        asm_d[8*lane_i +: 8] = byte_i;
    end

    // Assembly is cleared on every completed word, so upper lanes of a short
    // final word are already zero when it is copied out.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q   <= '0;
            word_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (accept_i) begin
                if (lane_i == 2'd3 || last_i) begin
                    word_q  <= asm_d;
                    asm_q   <= '0;
                    ready_q <= 1'b1;
                end else begin
                    asm_q <= asm_d;
                end
            end
        end
    end

    assign word_ready_o = ready_q;
    assign word_o       = word_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a program image from the UART byte stream into instruction memory, then releases the core.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int unsigned       IMAGE_BYTES = 52,
    parameter int unsigned       ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic              clk,
    input  logic              rst,
    uart_boot_loader_if.slave bus
);

    localparam int unsigned      CNT_W    = $clog2(IMAGE_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMAGE_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IMAGE_BYTES);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        lane_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              cpu_run_q;
    logic              load_err_q;

    logic              accept;
    logic              last_byte;
    logic              word_ready;
    logic [31:0]       word;

    // A framing error in the same cycle as a byte discards the byte.
    always_comb begin
        accept    = (state_q == ST_LOAD) && bus.byte_valid && !bus.frame_err
                    && (cnt_q != CNT_FULL);
        last_byte = (cnt_q == CNT_LAST);
    end

    uart_boot_loader_word_packer u_word_packer (
        .clk          (clk),
        .rst          (rst),
        .accept_i     (accept),
        .lane_i       (lane_q),
        .last_i       (last_byte),
        .byte_i       (bus.byte_data),
        .word_ready_o (word_ready),
        .word_o       (word)
    );

    // word_ready can only follow an accept made in LOAD, so a write already
    // pending when frame_err arrives still completes in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            cnt_q      <= '0;
            lane_q     <= '0;
            ptr_q      <= BASE_ADDR;
            cpu_run_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            if (word_ready) begin
                ptr_q <= ptr_q + ADDR_W'(1);
            end
            case (state_q)
                ST_LOAD: begin
                    if (bus.frame_err) begin
                        state_q    <= ST_ERROR;
                        load_err_q <= 1'b1;
                    end else begin
                        if (accept) begin
                            cnt_q  <= cnt_q + CNT_W'(1);
                            lane_q <= lane_q + 2'd1;
                        end
                        if (word_ready && cnt_q == CNT_FULL) begin
                            state_q   <= ST_DONE;
                            cpu_run_q <= 1'b1;
                        end
                    end
                end
                ST_DONE:  state_q <= ST_DONE;
                ST_ERROR: state_q <= ST_ERROR;
                default: begin
                    state_q    <= ST_ERROR;
                    load_err_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.mem_we     = word_ready;
    assign bus.mem_addr   = ptr_q;
    assign bus.mem_wdata  = word;
    assign bus.cpu_run    = cpu_run_q;
    assign bus.load_err   = load_err_q;
    assign bus.bytes_rcvd = cnt_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: three image sizes checked against a byte-list reference model.
module tb_uart_boot_loader;
    import uart_boot_loader_pkg::*;

    localparam int unsigned NB [3] = '{8, 52, 6};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        bv [3];
    logic        fe [3];
    logic [7:0]  bd [3];
    logic        we [3];
    logic        run [3];
    logic        lerr [3];
    logic [7:0]  addr [3];
    logic [31:0] wd [3];
    logic [7:0]  cnt [3];

    uart_boot_loader_if #(.IMAGE_BYTES(8),  .ADDR_W(8)) if0 ();
    uart_boot_loader_if #(.IMAGE_BYTES(52), .ADDR_W(8)) if1 ();
    uart_boot_loader_if #(.IMAGE_BYTES(6),  .ADDR_W(8)) if2 ();

    assign if0.byte_valid = bv[0];
    assign if0.byte_data  = bd[0];
    assign if0.frame_err  = fe[0];
    assign if1.byte_valid = bv[1];
    assign if1.byte_data  = bd[1];
    assign if1.frame_err  = fe[1];
    assign if2.byte_valid = bv[2];
    assign if2.byte_data  = bd[2];
    assign if2.frame_err  = fe[2];

    assign we[0]   = if0.mem_we;
    assign we[1]   = if1.mem_we;
    assign we[2]   = if2.mem_we;
    assign run[0]  = if0.cpu_run;
    assign run[1]  = if1.cpu_run;
    assign run[2]  = if2.cpu_run;
    assign lerr[0] = if0.load_err;
    assign lerr[1] = if1.load_err;
    assign lerr[2] = if2.load_err;
    assign addr[0] = if0.mem_addr;
    assign addr[1] = if1.mem_addr;
    assign addr[2] = if2.mem_addr;
    assign wd[0]   = if0.mem_wdata;
    assign wd[1]   = if1.mem_wdata;
    assign wd[2]   = if2.mem_wdata;
    assign cnt[0]  = 8'(if0.bytes_rcvd);
    assign cnt[1]  = 8'(if1.bytes_rcvd);
    assign cnt[2]  = 8'(if2.bytes_rcvd);

    uart_boot_loader #(.IMAGE_BYTES(8),  .ADDR_W(8), .BASE_ADDR(8'd0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    uart_boot_loader #(.IMAGE_BYTES(52), .ADDR_W(8), .BASE_ADDR(8'd0)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    uart_boot_loader #(.IMAGE_BYTES(6),  .ADDR_W(8), .BASE_ADDR(8'd0)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    // Reference model: the list of bytes the loader should have taken since reset.
    logic [7:0]  mb [3][64];
    int unsigned mn [3];
    bit          merr [3];

    // Write capture, owned by the monitor.
    logic [7:0]  cap_addr [3][80];
    logic [31:0] cap_data [3][80];
    int unsigned cap_n [3];
    int unsigned we_cyc [3];
    int unsigned run_cyc [3];
    logic        prev_run [3];
    int unsigned cyc = 0;

    int unsigned n_pass = 0;
    int unsigned n_chk  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                cap_n[d] = 0;
            end else if (we[d] === 1'b1) begin
                if (cap_n[d] < 80) begin
                    cap_addr[d][cap_n[d]] = addr[d];
                    cap_data[d][cap_n[d]] = wd[d];
                end
                cap_n[d]  = cap_n[d] + 1;
                we_cyc[d] = cyc;
            end
            if (run[d] === 1'b1 && prev_run[d] !== 1'b1) run_cyc[d] = cyc;
            prev_run[d] = run[d];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_word(input int d, input int unsigned k);
        logic [31:0] w = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            if (4 * k + j < mn[d]) w = w | (32'(mb[d][4 * k + j]) << (8 * j));
        end
        return w;
    endfunction

    task automatic do_reset();
        for (int d = 0; d < 3; d++) begin
            bv[d]   = 1'b0;
            fe[d]   = 1'b0;
            bd[d]   = 8'h00;
            mn[d]   = 0;
            merr[d] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One strobe cycle, then gap idle cycles; returns 1 time unit after an edge.
    task automatic drive(input int d, input logic [7:0] b, input bit v, input bit f,
                         input int unsigned gap);
        if (!merr[d] && mn[d] < NB[d]) begin
            if (f) merr[d] = 1'b1;
            else if (v) begin
                mb[d][mn[d]] = b;
                mn[d]++;
            end
        end
        bv[d] = v;
        bd[d] = b;
        fe[d] = f;
        @(posedge clk);
        #1;
        bv[d] = 1'b0;
        fe[d] = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap != 0) #1;
    endtask

    task automatic send_rand(input int d, input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            drive(d, 8'($urandom), 1'b1, 1'b0, $urandom_range(10, 13));
    endtask

    task automatic check_image(input int d, input string tag);
        bit          full = (mn[d] == NB[d]) && !merr[d];
        int unsigned ne   = full ? (NB[d] + 3) / 4 : mn[d] / 4;
        repeat (4) @(posedge clk);
        #1;
        chk($sformatf("%s.nwrites", tag), cap_n[d], ne);
        for (int unsigned k = 0; k < ne && k < cap_n[d] && k < 80; k++) begin
            chk($sformatf("%s.addr%0d", tag, k), 32'(cap_addr[d][k]), k % 256);
            chk($sformatf("%s.data%0d", tag, k), cap_data[d][k], exp_word(d, k));
        end
        chk($sformatf("%s.cpu_run", tag), 32'(run[d]), 32'(full));
        chk($sformatf("%s.load_err", tag), 32'(lerr[d]), 32'(merr[d]));
        chk($sformatf("%s.bytes_rcvd", tag), 32'(cnt[d]), mn[d]);
        chk($sformatf("%s.we_idle", tag), 32'(we[d]), 32'd0);
    endtask

    logic [7:0] t1 [8];

    initial begin
        t1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h10, 8'h00, 8'h00};
        for (int d = 0; d < 3; d++) begin
            bv[d] = 1'b0;
            fe[d] = 1'b0;
            bd[d] = 8'h00;
        end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst%0d.mem_we", d), 32'(we[d]), 32'd0);
            chk($sformatf("rst%0d.mem_addr", d), 32'(addr[d]), 32'd0);
            chk($sformatf("rst%0d.mem_wdata", d), wd[d], 32'd0);
            chk($sformatf("rst%0d.cpu_run", d), 32'(run[d]), 32'd0);
            chk($sformatf("rst%0d.load_err", d), 32'(lerr[d]), 32'd0);
            chk($sformatf("rst%0d.bytes_rcvd", d), 32'(cnt[d]), 32'd0);
        end
        do_reset();

        // Two-word image, latency of the completing byte and of cpu_run.
        for (int i = 0; i < 8; i++) drive(0, t1[i], 1'b1, 1'b0, (i == 7) ? 0 : 10);
        chk("t1.we_latency", 32'(we[0]), 32'd1);
        check_image(0, "t1");
        chk("t1.word0", cap_data[0][0], 32'h0000_0013);
        chk("t1.word1", cap_data[0][1], 32'h0000_10B7);
        chk("t1.run_latency", run_cyc[0] - we_cyc[0], 32'd1);
        send_rand(0, 3);
        check_image(0, "t1.after_done");

        // Full-size image of incrementing bytes.
        for (int i = 0; i < 52; i++) drive(1, 8'(i), 1'b1, 1'b0, 10);
        check_image(1, "t2");
        chk("t2.word12", cap_data[1][12], 32'h3332_3130);

        // Short final word with zero padding.
        for (int i = 0; i < 6; i++) drive(2, 8'(8'hAA + i), 1'b1, 1'b0, 10);
        check_image(2, "t3");
        chk("t3.word1", cap_data[2][1], 32'h0000_AFAE);

        // Framing error after the fifth byte.
        do_reset();
        send_rand(0, 5);
        drive(0, 8'h00, 1'b0, 1'b1, 10);
        send_rand(0, 3);
        check_image(0, "t4");

        // Framing error together with a byte: the byte is dropped.
        do_reset();
        send_rand(2, 2);
        drive(2, 8'($urandom), 1'b1, 1'b1, 10);
        send_rand(2, 2);
        check_image(2, "t4b");

        // Byte arriving in the same cycle as the write pulse.
        do_reset();
        send_rand(0, 3);
        drive(0, 8'($urandom), 1'b1, 1'b0, 0);
        chk("t5.coincide", 32'(we[0]), 32'd1);
        drive(0, 8'($urandom), 1'b1, 1'b0, 10);
        send_rand(0, 3);
        check_image(0, "t5");

        // Reset mid-load, full reload, then ignored extra bytes.
        do_reset();
        send_rand(0, 3);
        do_reset();
        send_rand(0, 8);
        check_image(0, "t6");
        send_rand(0, 4);
        check_image(0, "t6.extra");

        // Random images with an optional framing error somewhere in the stream.
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int d = 1; d < 3; d++) begin
                int unsigned ep = $urandom_range(0, NB[d] + NB[d] / 2);
                for (int unsigned i = 0; i < NB[d]; i++) begin
                    if (i == ep) drive(d, 8'h00, 1'b0, 1'b1, $urandom_range(10, 13));
                    drive(d, 8'($urandom), 1'b1, 1'b0, $urandom_range(10, 13));
                end
                check_image(d, $sformatf("rnd%0d.dut%0d", it, d));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
